// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite slave with a local word array. It supports byte, halfword and word
// writes using a lane mask, and returns registered read data. Every OKAY data
// phase can be stretched by a fixed number of wait states. Misaligned or
// oversize transfers receive a two-cycle ERROR response.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no data phase in flight, HREADYOUT=1, HRESP=OKAY
// DATA  | OKAY data phase; wcnt counts wait states down, completes at 0
// ERR1  | first ERROR cycle, HRESP=1, HREADYOUT=0
// ERR2  | second ERROR cycle, HRESP=1, HREADYOUT=1, next transfer allowed
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         IW    = ADDR_WIDTH - 2;
    localparam int         DEPTH = 2 ** IW;
    localparam logic [2:0] WS    = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state;
    logic [2:0]    wcnt;
    logic [IW-1:0] addr_q;
    logic [3:0]    mask_q;
    logic          write_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          size_err;
    logic [3:0]    lane_mask;
    logic [IW-1:0] haddr_idx;
    logic          commit;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          unused_inputs;

    // HBURST is informational, HTRANS[0] only separates NONSEQ from SEQ and
    // BUSY from IDLE, and the upper address bits alias onto the array.
    assign unused_inputs = ^{HBURST, HTRANS[0], HADDR[31:ADDR_WIDTH]};

    // An address phase is taken only while the previous data phase is finishing.
    assign accept    = HSEL & HTRANS[1] & HREADYOUT;
    assign haddr_idx = HADDR[ADDR_WIDTH-1:2];

    // A write lands at the edge where its data phase finishes without wait states.
    assign commit = (state == ST_DATA) && (wcnt == 3'd0) && write_q;

    // Decode the address-phase size into a little-endian lane mask and flag misalignment.
    always_comb begin
        lane_mask = 4'b0000;
        size_err  = 1'b0;
        case (HSIZE)
            3'd0: lane_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                size_err  = HADDR[0];
            end
            3'd2: begin
                lane_mask = 4'b1111;
                size_err  = |HADDR[1:0];
            end
            default: size_err = 1'b1;
        endcase
    end

    // Read word for capture. A write finishing at the same edge is merged lane by
    // lane, so a read issued right behind a write never sees stale data.
    always_comb begin
        rd_idx  = accept ? haddr_idx : addr_q;
        rd_word = mem[rd_idx];
        if (commit && (addr_q == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Byte-lane array write. A reset on the commit edge discards the write.
    always_ff @(posedge PCLK) begin
        if (!PRESET && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    mem[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Transfer FSM. HREADYOUT, HRESP and HRDATA are registered outputs of this FSM.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            wcnt      <= 3'd0;
            addr_q    <= '0;
            mask_q    <= 4'b0000;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'd0;
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b1;
        end else if ((state == ST_DATA) && (wcnt != 3'd0)) begin
            // Wait state. Address-phase inputs are ignored until HREADYOUT rises.
            wcnt      <= wcnt - 3'd1;
            HREADYOUT <= (wcnt == 3'd1);
            if ((wcnt == 3'd1) && !write_q) begin
                HRDATA <= rd_word;
            end
        end else if (accept) begin
            // IDLE, ERR2 or a finishing DATA phase, with a new transfer accepted.
            addr_q  <= haddr_idx;
            mask_q  <= lane_mask;
            write_q <= HWRITE;
            if (size_err) begin
                state     <= ST_ERR1;
                wcnt      <= 3'd0;
                HREADYOUT <= 1'b0;
                HRESP     <= 1'b1;
                HRDATA    <= 32'd0;
            end else begin
                state     <= ST_DATA;
                wcnt      <= WS;
                HREADYOUT <= (WS == 3'd0);
                HRESP     <= 1'b0;
                if (!HWRITE && (WS == 3'd0)) begin
                    HRDATA <= rd_word;
                end
            end
        end else begin
            state     <= ST_IDLE;
            wcnt      <= 3'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// Drives one instance with WAIT_STATES=0 and one with WAIT_STATES=3 over a
// shared bus; HSEL is steered to the active one. Transfers come from a queue.
// Expected read data comes from a byte-level memory model updated in issue order.
module tb_ahb_sram_slave;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << (AW - 2);

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        hsel_m = 1'b0;
    logic [31:0] HADDR = '0;
    logic [2:0]  HBURST = '0;
    logic [2:0]  HSIZE = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        use3 = 1'b0;

    logic        hsel0, hsel3;
    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rd0, rd3;
    logic        ready, resp;
    logic [31:0] rdata;

    assign hsel0 = hsel_m & ~use3;
    assign hsel3 = hsel_m & use3;
    assign ready = use3 ? rdy3 : rdy0;
    assign resp  = use3 ? resp3 : resp0;
    assign rdata = use3 ? rd3 : rd0;

    always #5 PCLK = ~PCLK;

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .HSEL(hsel0), .HADDR(HADDR),
        .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .HSEL(hsel3), .HADDR(HADDR),
        .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3)
    );

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit [2:0]    burst;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          tab;
        bit          exp_err;
        logic [31:0] exp_data;
    } xfer_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    xfer_t       q[$];
    logic [31:0] mdl [0:1][0:DEPTH-1];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        return (a & ((32'd1 << sz) - 32'd1)) != 32'd0;
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd, input bit [1:0] tr);
        xfer_t x;
        x.sel = 1'b1; x.trans = tr; x.burst = 3'd0; x.wr = wr; x.addr = a; x.size = sz;
        x.wdata = wd; x.tab = 1'b0; x.exp_err = 1'b0; x.exp_data = '0;
        return x;
    endfunction

    function automatic xfer_t from_vec(input vec_t v, input bit [1:0] tr);
        xfer_t x;
        x = mk(v.wr, v.addr, v.size, v.wdata, tr);
        x.tab = 1'b1; x.exp_err = v.exp_err; x.exp_data = v.exp_data;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int    k;
        x.sel = ($urandom_range(0, 9) != 0);
        k = $urandom_range(0, 9);
        x.trans = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 5) ? 2'd2 : 2'd3;
        x.burst = 3'($urandom_range(0, 7));
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = $urandom;
        if ($urandom_range(0, 1) == 1) x.addr[AW-1:0] = AW'($urandom_range(0, 31));
        if ((x.size <= 3'd2) && ($urandom_range(0, 9) < 8))
            x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        x.wdata = $urandom; x.tab = 1'b0; x.exp_err = 1'b0; x.exp_data = '0;
        return x;
    endfunction

    // Bus master: issues queued transfers back to back, honours HREADYOUT, and
    // checks each data phase when it completes. cycles counts clock edges used.
    task automatic run_queue(output int cycles);
        xfer_t       cur;
        bit          cur_v = 1'b0;
        bit          pv = 1'b0;
        bit          p_wr = 1'b0, p_err = 1'b0, p_tab = 1'b0, p_terr = 1'b0;
        logic [31:0] p_wd = '0, p_exp = '0, p_tdata = '0;
        int          waits = 0;
        int          ws;
        int          lo;
        int          idx;
        logic [31:0] w;
        ws = use3 ? 3 : 0;
        cycles = 0;
        forever begin
            if (pv) begin
                if (!ready) begin
                    waits++;
                    check("wait_resp", 32'(resp), 32'(p_err));
                end else begin
                    check("resp", 32'(resp), 32'(p_err));
                    check("wait_cycles", 32'(waits), p_err ? 32'd1 : 32'(ws));
                    if (!p_wr) check("rdata_model", rdata, p_exp);
                    if (p_tab) begin
                        check("tab_resp", 32'(resp), 32'(p_terr));
                        if (!p_wr) check("tab_rdata", rdata, p_tdata);
                    end
                end
            end
            if (!cur_v && (q.size() > 0)) begin
                cur = q.pop_front();
                cur_v = 1'b1;
            end
            if (!pv && !cur_v) break;
            if (cur_v) begin
                hsel_m = cur.sel; HTRANS = cur.trans; HBURST = cur.burst;
                HWRITE = cur.wr; HADDR = cur.addr; HSIZE = cur.size;
            end else begin
                hsel_m = 1'b0; HTRANS = 2'd0;
            end
            HWDATA = pv ? p_wd : 32'd0;
            if (ready) begin
                pv = 1'b0;
                if (cur_v) begin
                    if (cur.sel && cur.trans[1]) begin
                        pv = 1'b1; waits = 0;
                        p_wr = cur.wr; p_err = is_err(cur.addr, cur.size);
                        p_wd = cur.wdata; p_tab = cur.tab; p_terr = cur.exp_err;
                        p_tdata = cur.exp_data;
                        idx = int'(cur.addr[AW-1:2]);
                        if (!p_err && p_wr) begin
                            w  = mdl[use3][idx];
                            lo = int'(cur.addr[1:0]);
                            for (int b = lo; b < lo + (1 << cur.size); b++)
                                w[8*b +: 8] = cur.wdata[8*b +: 8];
                            mdl[use3][idx] = w;
                        end
                        p_exp = (p_err || p_wr) ? 32'd0 : mdl[use3][idx];
                    end
                    cur_v = 1'b0;
                end
            end
            @(posedge PCLK); #1;
            cycles++;
            if (cycles > 5000) begin
                n_cmp++; n_bad++;
                $display("FAIL run_queue_timeout: still busy after %0d cycles, expected completion", cycles);
                q.delete();
                break;
            end
        end
        hsel_m = 1'b0; HTRANS = 2'd0; HWDATA = 32'd0;
    endtask

    vec_t tbl[$];
    int   cyc;

    initial begin
        // reset values on both instances
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_resp0",  32'(resp0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd1);
        check("rst_resp3",  32'(resp3), 32'd0);
        check("rst_rdata3", rd3, 32'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // fill both arrays so every later read has a known model value
        for (int s = 0; s < 2; s++) begin
            use3 = 1'(s);
            for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b1, 32'(i * 4), 3'd2, $urandom, 2'd2));
            run_queue(cyc);
        end

        // directed vectors, zero wait states
        use3 = 1'b0;
        tbl.push_back('{1'b1, 32'h010, 3'd2, 32'h11223344, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'h11223344});
        tbl.push_back('{1'b1, 32'h020, 3'd2, 32'h00000000, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 32'h021, 3'd0, 32'h0000AA00, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 32'h022, 3'd1, 32'hBEEF0000, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, 32'hBEEFAA00});
        tbl.push_back('{1'b1, 32'h040, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b1, 32'h042, 3'd2, 32'h55555555, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b0, 32'h043, 3'd2, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 32'h023, 3'd1, 32'h77777777, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 32'h030, 3'd3, 32'h66666666, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 32'hFFFF_F040, 3'd2, 32'h0,  1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b0, 32'h041, 3'd0, 32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, 32'hBEEFAA00});
        for (int i = 0; i < tbl.size(); i++) q.push_back(from_vec(tbl[i], 2'd2));
        run_queue(cyc);

        // throughput: 8 back-to-back OKAY transfers take 9 edges
        for (int i = 0; i < 8; i++)
            q.push_back(mk(1'(i % 2 == 0), 32'h200 + 32'((i / 2) * 4), 3'd2, 32'hA0A0_0000 + 32'(i),
                           (i == 0) ? 2'd2 : 2'd3));
        run_queue(cyc);
        check("b2b_cycles", 32'(cyc), 32'd9);

        // 4-beat SEQ write burst with 3 wait states, then read back
        use3 = 1'b1;
        for (int i = 0; i < 4; i++)
            q.push_back(mk(1'b1, 32'h100 + 32'(i * 4), 3'd2, 32'h5A5A_0100 + 32'(i), (i == 0) ? 2'd2 : 2'd3));
        run_queue(cyc);
        check("burst_cycles", 32'(cyc), 32'd17);
        tbl.delete();
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 32'h100 + 32'(i * 4), 3'd2, 32'h0, 1'b0, 32'h5A5A_0100 + 32'(i)});
        tbl.push_back('{1'b1, 32'h080, 3'd2, 32'h12345678, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'h080, 3'd2, 32'h0,        1'b0, 32'h12345678});
        for (int i = 0; i < tbl.size(); i++) q.push_back(from_vec(tbl[i], 2'd2));
        run_queue(cyc);

        // reset during a write wait state drops the write
        hsel_m = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'h080; HSIZE = 3'd2;
        @(posedge PCLK); #1;
        hsel_m = 1'b0; HTRANS = 2'd0; HWDATA = 32'hDEADBEEF;
        check("rst_mid_wait_ready", 32'(ready), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_resp",  32'(resp), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        PRESET = 1'b0; HWDATA = 32'd0;
        repeat (6) @(posedge PCLK);
        #1;
        q.push_back(from_vec('{1'b0, 32'h080, 3'd2, 32'h0, 1'b0, 32'h12345678}, 2'd2));
        run_queue(cyc);

        // randomized traffic against the model on both instances
        for (int s = 0; s < 2; s++) begin
            use3 = 1'(s);
            for (int i = 0; i < 400; i++) q.push_back(rand_xfer());
            run_queue(cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
